// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RISC-V pipeline: forwarding, load-use, branch, mul/div busy FSM
// and data-memory wait stalls. Define HAZ_PERF_EN to build the saturating stall/flush counters.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              Rs1UsedD,
    input  logic              Rs2UsedD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              ResultSrcE0,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MdStartE,
    input  logic              MemReqM,
    input  logic              DMemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_busy;

    logic w_mem_wait;
    logic w_md_stall;
    logic w_hold_e;
    logic w_lw_hit;
    logic w_lw_stall;
    logic w_branch;
    logic w_stall_fd;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_m;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic              we_w);
        if (rs != '0 && we_m && rs == rd_m) begin
            return 2'b10;
        end else if (rs != '0 && we_w && rs == rd_w) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_mem_wait = MemReqM & ~DMemReadyM;
    assign w_md_stall = ((r_state == StIdle) & MdStartE) | (r_state == StBusy);
    assign w_hold_e   = w_mem_wait | w_md_stall;

    assign w_lw_hit   = ResultSrcE0 & (RdE != '0) &
                        ((Rs1UsedD & (RdE == Rs1D)) | (Rs2UsedD & (RdE == Rs2D)));
    assign w_lw_stall = w_lw_hit & ~w_hold_e;
    // A held E stage keeps its branch; it is acted on once E advances.
    assign w_branch   = PCSrcE & ~w_hold_e;

    assign w_stall_fd = w_hold_e | w_lw_stall;
    assign w_flush_d  = w_branch & ~w_stall_fd;
    assign w_flush_e  = (w_lw_stall | w_branch) & ~w_hold_e;
    assign w_flush_m  = w_md_stall & ~w_mem_wait;

    // All stage controls are forced inactive while reset is asserted.
    assign StallF    = reset_n & w_stall_fd;
    assign StallD    = reset_n & w_stall_fd;
    assign StallE    = reset_n & w_hold_e;
    assign StallM    = reset_n & w_mem_wait;
    assign FlushD    = reset_n & w_flush_d;
    assign FlushE    = reset_n & w_flush_e;
    assign FlushM    = reset_n & w_flush_m;
    assign FlushW    = reset_n & w_mem_wait;
    assign ForwardAE = reset_n ? fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
    assign ForwardBE = reset_n ? fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
    assign MdBusy    = r_md_busy;

    // Mul/div sequencer; BUSY runs to completion regardless of MdStartE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (MdStartE) begin
                        r_state   <= StBusy;
                        r_cnt     <= CNT_W'(MD_LAT - 1);
                        r_md_busy <= 1'b1;
                    end
                end
                StBusy: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (!w_mem_wait) begin
                        r_state   <= StIdle;
                        r_md_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_md_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_fd && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((w_flush_d | w_flush_e | w_flush_m) && r_flush_cnt != 32'hFFFF_FFFF) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = 32'h0;
    assign FlushCnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: directed scenarios then random traffic, checked against
// a cycle-age model of the mul/div op and the stall/flush/forward rules.
module tb_hazard_ctrl_mc;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned MD_LAT = 4;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic              rst_n;
        logic [REG_AW-1:0] rs1d;
        logic [REG_AW-1:0] rs2d;
        logic              u1;
        logic              u2;
        logic [REG_AW-1:0] rs1e;
        logic [REG_AW-1:0] rs2e;
        logic [REG_AW-1:0] rde;
        logic [REG_AW-1:0] rdm;
        logic [REG_AW-1:0] rdw;
        logic              lde;
        logic              rwm;
        logic              rww;
        logic              pcsrc;
        logic              mdstart;
        logic              memreq;
        logic              dready;
    } in_t;

    typedef struct packed {
        logic        sf, sd, se, sm;
        logic        fd, fe, fm, fw;
        logic [1:0]  fa, fb;
        logic        busy;
        logic [31:0] sc, fc;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              Rs1UsedD, Rs2UsedD, ResultSrcE0, RegWriteM, RegWriteW;
    logic              PCSrcE, MdStartE, MemReqM, DMemReadyM;
    logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdBusy;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [31:0]       StallCnt, FlushCnt;

    hazard_ctrl_mc #(
        .REG_AW(REG_AW),
        .MD_LAT(MD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1UsedD   (Rs1UsedD),
        .Rs2UsedD   (Rs2UsedD),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE0(ResultSrcE0),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MdStartE   (MdStartE),
        .MemReqM    (MemReqM),
        .DMemReadyM (DMemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MdBusy     (MdBusy),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        exp_q[$];

    in_t         st;       // next-cycle stimulus
    in_t         cur;      // stimulus currently applied
    // Model: -1 = no op, 0..MD_LAT = cycles since op entered E, MD_LAT+1 = finished, waiting to leave
    int          m_age = -1;
    logic        m_sf, m_fany, m_mem_wait;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs, input in_t x);
        if (rs == 0) return 2'b00;
        if (x.rwm && rs == x.rdm) return 2'b10;
        if (x.rww && rs == x.rdw) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply_inputs();
        cur         = st;
        reset_n     = st.rst_n;
        Rs1D        = st.rs1d;
        Rs2D        = st.rs2d;
        Rs1UsedD    = st.u1;
        Rs2UsedD    = st.u2;
        Rs1E        = st.rs1e;
        Rs2E        = st.rs2e;
        RdE         = st.rde;
        RdM         = st.rdm;
        RdW         = st.rdw;
        ResultSrcE0 = st.lde;
        RegWriteM   = st.rwm;
        RegWriteW   = st.rww;
        PCSrcE      = st.pcsrc;
        MdStartE    = st.mdstart;
        MemReqM     = st.memreq;
        DMemReadyM  = st.dready;
    endtask

    task automatic model_predict();
        exp_t e;
        logic md_hold, hold_e, lu, br, sfd;
        e = '0;
        if (!cur.rst_n) begin
            m_age      = -1;
            m_scnt     = '0;
            m_fcnt     = '0;
            m_sf       = 1'b0;
            m_fany     = 1'b0;
            m_mem_wait = 1'b0;
            exp_q.push_back(e);
            return;
        end
        m_mem_wait = cur.memreq && !cur.dready;
        md_hold    = (m_age < 0) ? cur.mdstart : (m_age <= int'(MD_LAT));
        hold_e     = m_mem_wait || md_hold;
        lu = cur.lde && cur.rde != 0 &&
             ((cur.u1 && cur.rde == cur.rs1d) || (cur.u2 && cur.rde == cur.rs2d)) && !hold_e;
        br   = cur.pcsrc && !hold_e;
        sfd  = hold_e || lu;
        e.sf = sfd;
        e.sd = sfd;
        e.se = hold_e;
        e.sm = m_mem_wait;
        e.fd = br && !sfd;
        e.fe = (lu || br) && !hold_e;
        e.fm = md_hold && !m_mem_wait;
        e.fw = m_mem_wait;
        e.fa = ref_fwd(cur.rs1e, cur);
        e.fb = ref_fwd(cur.rs2e, cur);
        e.busy = (m_age > 0);
`ifdef HAZ_PERF_EN
        e.sc = m_scnt;
        e.fc = m_fcnt;
`endif
        m_sf   = e.sf;
        m_fany = e.fd || e.fe || e.fm;
        exp_q.push_back(e);
    endtask

    task automatic model_tick();
        if (!cur.rst_n) return;
        if (m_sf && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
        if (m_fany && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
        if (m_age < 0) begin
            if (cur.mdstart) m_age = 1;
        end else if (m_age <= int'(MD_LAT)) begin
            m_age = m_age + 1;
        end else if (!m_mem_wait) begin
            m_age = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        apply_inputs();
        model_predict();
    endtask

    task automatic idle_stage();
        st       = '0;
        st.rst_n = 1'b1;
        st.dready = 1'b1;
    endtask

    task automatic rand_stage();
        logic keep_md;
        keep_md    = (m_age >= 0 && m_age <= int'(MD_LAT)) || (m_age < 0 && cur.mdstart);
        st.rst_n   = ($urandom_range(0, 299) != 0);
        st.rs1d    = REG_AW'($urandom_range(0, 3));
        st.rs2d    = REG_AW'($urandom_range(0, 3));
        st.u1      = ($urandom_range(0, 1) == 1);
        st.u2      = ($urandom_range(0, 1) == 1);
        st.rs1e    = REG_AW'($urandom_range(0, 3));
        st.rs2e    = REG_AW'($urandom_range(0, 3));
        st.rde     = REG_AW'($urandom_range(0, 3));
        st.rdm     = REG_AW'($urandom_range(0, 3));
        st.rdw     = REG_AW'($urandom_range(0, 3));
        st.lde     = ($urandom_range(0, 2) == 0);
        st.rwm     = ($urandom_range(0, 1) == 1);
        st.rww     = ($urandom_range(0, 1) == 1);
        st.pcsrc   = ($urandom_range(0, 3) == 0);
        st.mdstart = keep_md ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 5) == 0);
        st.memreq  = ($urandom_range(0, 2) == 0);
        st.dready  = ($urandom_range(0, 1) == 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queued prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("StallF",    32'(StallF),    32'(e.sf));
            chk("StallD",    32'(StallD),    32'(e.sd));
            chk("StallE",    32'(StallE),    32'(e.se));
            chk("StallM",    32'(StallM),    32'(e.sm));
            chk("FlushD",    32'(FlushD),    32'(e.fd));
            chk("FlushE",    32'(FlushE),    32'(e.fe));
            chk("FlushM",    32'(FlushM),    32'(e.fm));
            chk("FlushW",    32'(FlushW),    32'(e.fw));
            chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
            chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
            chk("MdBusy",    32'(MdBusy),    32'(e.busy));
            chk("StallCnt",  StallCnt,       e.sc);
            chk("FlushCnt",  FlushCnt,       e.fc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        st       = '0;
        st.rst_n = 1'b0;
        apply_inputs();

        // Reset with hazard-provoking inputs: every control must stay inactive.
        st = '{rst_n: 1'b0, rs1d: 5'd7, rs2d: 5'd7, u1: 1'b1, u2: 1'b1, rs1e: 5'd5, rs2e: 5'd5,
               rde: 5'd7, rdm: 5'd5, rdw: 5'd5, lde: 1'b1, rwm: 1'b1, rww: 1'b1, pcsrc: 1'b1,
               mdstart: 1'b1, memreq: 1'b1, dready: 1'b0};
        repeat (3) cycle();
        idle_stage();
        cycle();

        // Forwarding priority M over W, and x0 never forwarded
        st.rs1e = 5'd5; st.rs2e = 5'd6; st.rdm = 5'd5; st.rdw = 5'd5;
        st.rwm = 1'b1; st.rww = 1'b1;
        cycle();
        st.rwm = 1'b0; st.rdw = 5'd6;
        cycle();
        st.rs1e = 5'd0; st.rdw = 5'd0; st.rww = 1'b1;
        cycle();

        // Load-use only counts operands that are actually read
        idle_stage();
        st.lde = 1'b1; st.rde = 5'd7; st.rs2d = 5'd7; st.u2 = 1'b0; st.rs1d = 5'd3; st.u1 = 1'b1;
        cycle();
        st.u2 = 1'b1;
        cycle();
        idle_stage();
        cycle();

        // Uncontended mul/div: held while in E
        st.mdstart = 1'b1;
        repeat (6) cycle();
        idle_stage();
        repeat (2) cycle();

        // Memory wait overlapping the end of a mul/div
        st.mdstart = 1'b1;
        repeat (4) cycle();
        st.memreq = 1'b1; st.dready = 1'b0;
        repeat (3) cycle();
        st.dready = 1'b1;
        cycle();
        idle_stage();
        repeat (2) cycle();

        // Branch during and after a memory wait
        st.memreq = 1'b1; st.dready = 1'b0; st.pcsrc = 1'b1;
        cycle();
        st.dready = 1'b1;
        cycle();
        idle_stage();
        cycle();

        // Async reset mid-BUSY, then a clean op
        st.mdstart = 1'b1;
        repeat (3) cycle();
        st.rst_n = 1'b0; st.mdstart = 1'b0;
        cycle();
        idle_stage();
        repeat (2) cycle();
        st.mdstart = 1'b1;
        repeat (6) cycle();
        idle_stage();
        repeat (2) cycle();

        for (int i = 0; i < 2000; i++) begin
            rand_stage();
            cycle();
        end
        idle_stage();
        repeat (8) cycle();

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
